// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: pipeline packets, FSM states, access sizes.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package mem_stage_pkg;

    localparam int unsigned XLEN = `DATA_WIDTH;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } MEM_STATE;

    // mem_size[1:0] is the access size, mem_size[2] selects zero-extension on loads
    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] rs2_value;
        logic            rd_mem;
        logic            wr_mem;
        logic [2:0]      mem_size;
        logic [4:0]      dest_reg_addr;
        logic [XLEN-1:0] NPC;
        logic            halt;
        logic            illegal;
        logic            csr_op;
        logic            valid;
    } EX_MEM_PACKET;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      dest_reg_addr;
        logic [XLEN-1:0] NPC;
        logic            halt;
        logic            illegal;
        logic            csr_op;
        logic            valid;
    } MEM_WB_PACKET;

    // Natural alignment check: the low address bits below the access size must be zero
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lane);
        logic mis;
        case (size)
            BYTE:    mis = 1'b0;
            HALF:    mis = lane[0];
            WORD:    mis = |lane[1:0];
            default: mis = |lane;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering for the memory stage: store data/strobes and load extraction.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic [2:0]            lane,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] rs2_value,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic [DATA_WIDTH-1:0] load_value
);

    logic [5:0]            shamt;
    logic [STRB_WIDTH-1:0] base_strb;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  sx;

    // Shift store data up into its lane, shift load data down and extend by size
    always_comb begin
        shamt   = {lane, 3'b000};
        wdata   = rs2_value << shamt;
        shifted = rdata >> shamt;
        sx      = ~funct3[2];
        case (funct3[1:0])
            BYTE: begin
                base_strb  = STRB_WIDTH'(8'h01);
                load_value = {{(DATA_WIDTH-8){sx & shifted[7]}}, shifted[7:0]};
            end
            HALF: begin
                base_strb  = STRB_WIDTH'(8'h03);
                load_value = {{(DATA_WIDTH-16){sx & shifted[15]}}, shifted[15:0]};
            end
            WORD: begin
                base_strb  = STRB_WIDTH'(8'h0F);
                load_value = {{(DATA_WIDTH-32){sx & shifted[31]}}, shifted[31:0]};
            end
            default: begin
                base_strb  = STRB_WIDTH'(8'hFF);
                load_value = shifted;
            end
        endcase
        wstrb = base_strb << lane;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: single-outstanding load/store over a valid/ready port.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  EX_MEM_PACKET          ex_packet_in,
    output logic                  mem_stall,
    output logic                  proc2mem_valid,
    output logic                  proc2mem_we,
    output logic [DATA_WIDTH-1:0] proc2mem_addr,
    output logic [DATA_WIDTH-1:0] proc2mem_wdata,
    output logic [STRB_WIDTH-1:0] proc2mem_wstrb,
    input  logic                  mem2proc_ready,
    input  logic                  mem2proc_rvalid,
    input  logic [DATA_WIDTH-1:0] mem2proc_rdata,
    input  logic                  mem2proc_err,
    output MEM_WB_PACKET          mem_packet_out
);

    MEM_STATE              state_q, state_d;
    MEM_WB_PACKET          out_q, out_d;
    MEM_WB_PACKET          pass;
    logic [2:0]            lane;
    logic                  is_mem;
    logic                  mis;
    logic [DATA_WIDTH-1:0] align_wdata;
    logic [STRB_WIDTH-1:0] align_wstrb;
    logic [DATA_WIDTH-1:0] load_value;

    assign lane = ex_packet_in.alu_result[2:0];

    mem_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_align (
        .lane       (lane),
        .funct3     (ex_packet_in.mem_size),
        .rs2_value  (ex_packet_in.rs2_value),
        .rdata      (mem2proc_rdata),
        .wdata      (align_wdata),
        .wstrb      (align_wstrb),
        .load_value (load_value)
    );

    // Next-state, stall, bus request and next writeback packet
    always_comb begin
        state_d        = state_q;
        out_d          = '0;
        mem_stall      = 1'b0;
        proc2mem_valid = 1'b0;

        is_mem = ex_packet_in.valid && (ex_packet_in.rd_mem || ex_packet_in.wr_mem)
                 && !ex_packet_in.illegal;
        mis    = is_misaligned(ex_packet_in.mem_size[1:0], lane);

        pass.result        = ex_packet_in.alu_result;
        pass.dest_reg_addr = ex_packet_in.dest_reg_addr;
        pass.NPC           = ex_packet_in.NPC;
        pass.halt          = ex_packet_in.halt;
        pass.illegal       = ex_packet_in.illegal;
        pass.csr_op        = ex_packet_in.csr_op;
        pass.valid         = ex_packet_in.valid;

        case (state_q)
            IDLE: begin
                if (!is_mem) begin
                    out_d = pass;
                end else if (mis) begin
                    out_d               = pass;
                    out_d.illegal       = 1'b1;
                    out_d.dest_reg_addr = '0;
                end else begin
                    mem_stall = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                proc2mem_valid = 1'b1;
                mem_stall      = 1'b1;
                if (mem2proc_ready) begin
                    if (ex_packet_in.wr_mem) begin
                        mem_stall     = 1'b0;
                        out_d         = pass;
                        out_d.result  = '0;
                        out_d.illegal = pass.illegal | mem2proc_err;
                        state_d       = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                mem_stall = 1'b1;
                if (mem2proc_rvalid) begin
                    mem_stall     = 1'b0;
                    out_d         = pass;
                    out_d.result  = load_value;
                    out_d.illegal = pass.illegal | mem2proc_err;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign proc2mem_we    = proc2mem_valid & ex_packet_in.wr_mem;
    assign proc2mem_addr  = {ex_packet_in.alu_result[DATA_WIDTH-1:3], 3'b000};
    assign proc2mem_wdata = align_wdata;
    assign proc2mem_wstrb = (proc2mem_valid && ex_packet_in.wr_mem) ? align_wstrb : '0;
    assign mem_packet_out = out_q;

    // State and writeback packet registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a transaction-level reference model.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    EX_MEM_PACKET ex_packet_in;
    logic         mem_stall, proc2mem_valid, proc2mem_we;
    logic [63:0]  proc2mem_addr, proc2mem_wdata;
    logic [7:0]   proc2mem_wstrb;
    logic         mem2proc_ready, mem2proc_rvalid, mem2proc_err;
    logic [63:0]  mem2proc_rdata;
    MEM_WB_PACKET mem_packet_out;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    mem_stage #(.DATA_WIDTH(64), .STRB_WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_packet_in    (ex_packet_in),
        .mem_stall       (mem_stall),
        .proc2mem_valid  (proc2mem_valid),
        .proc2mem_we     (proc2mem_we),
        .proc2mem_addr   (proc2mem_addr),
        .proc2mem_wdata  (proc2mem_wdata),
        .proc2mem_wstrb  (proc2mem_wstrb),
        .mem2proc_ready  (mem2proc_ready),
        .mem2proc_rvalid (mem2proc_rvalid),
        .mem2proc_rdata  (mem2proc_rdata),
        .mem2proc_err    (mem2proc_err),
        .mem_packet_out  (mem_packet_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference load: gather bytes starting at the lane, then extend
    function automatic logic [63:0] model_load(input logic [63:0] rd, input int unsigned lane,
                                               input logic [2:0] f3);
        int unsigned nb = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int unsigned i = 0; i < nb; i++)
            if (lane + i < 8) v[8*i +: 8] = rd[8*(lane+i) +: 8];
        if (!f3[2] && nb < 8 && v[8*nb-1])
            for (int unsigned i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic EX_MEM_PACKET mk(input logic [63:0] addr, input logic [63:0] rs2,
                                        input logic rd, input logic wr, input logic [2:0] sz,
                                        input logic [4:0] dst);
        EX_MEM_PACKET p;
        p.alu_result    = addr;
        p.rs2_value     = rs2;
        p.rd_mem        = rd;
        p.wr_mem        = wr;
        p.mem_size      = sz;
        p.dest_reg_addr = dst;
        p.NPC           = addr ^ 64'h0000_0000_0040_0004;
        p.halt          = 1'b0;
        p.illegal       = 1'b0;
        p.csr_op        = 1'b0;
        p.valid         = 1'b1;
        return p;
    endfunction

    // Present one instruction, act as memory, check bus request, stall length and result.
    // Called at posedge+1; returns at posedge+1 after the instruction retires.
    task automatic run_instr(input EX_MEM_PACKET p, input int unsigned rdy_dly,
                             input int unsigned rv_dly, input logic err,
                             input logic [63:0] rd, output logic [63:0] res_o);
        int unsigned lane, nb, stall_cnt, wait_cnt, resp_cnt, exp_stall;
        logic is_mem, mis, done, load_acc, req_seen, stalled;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wd, mask, exp_res;
        logic        exp_ill;

        lane   = p.alu_result[2:0];
        nb     = 1 << p.mem_size[1:0];
        is_mem = p.valid && (p.rd_mem || p.wr_mem) && !p.illegal;
        mis    = is_mem && ((p.alu_result % 64'(nb)) != 0);
        exp_strb = '0;
        exp_wd   = '0;
        mask     = '0;
        for (int unsigned i = 0; i < nb; i++) begin
            if (lane + i < 8) begin
                exp_strb[lane+i]           = 1'b1;
                exp_wd[8*(lane+i) +: 8]    = p.rs2_value[8*i +: 8];
                mask[8*(lane+i) +: 8]      = 8'hFF;
            end
        end

        ex_packet_in = p;
        done = 0; load_acc = 0; req_seen = 0;
        stall_cnt = 0; wait_cnt = 0; resp_cnt = 0;
        for (int unsigned cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            mem2proc_ready  = 1'b0;
            mem2proc_rvalid = 1'b0;
            mem2proc_err    = 1'b0;
            mem2proc_rdata  = {$urandom, $urandom};
            if (load_acc) begin
                resp_cnt++;
                if (resp_cnt == rv_dly) begin
                    mem2proc_rvalid = 1'b1;
                    mem2proc_rdata  = rd;
                    mem2proc_err    = err;
                end
            end
            if (proc2mem_valid) begin
                if (!req_seen) begin
                    chk("req_addr", proc2mem_addr, {p.alu_result[63:3], 3'b000});
                    chk("req_we", proc2mem_we, p.wr_mem);
                    chk("req_wstrb", proc2mem_wstrb, p.wr_mem ? exp_strb : 8'h00);
                    if (p.wr_mem) chk("req_wdata", proc2mem_wdata & mask, exp_wd);
                end
                req_seen = 1;
                if (wait_cnt == rdy_dly) begin
                    mem2proc_ready = 1'b1;
                    if (p.wr_mem) mem2proc_err = err;
                    else load_acc = 1;
                end
                wait_cnt++;
            end
            #1;
            stalled = mem_stall;
            if (stalled) stall_cnt++;
            @(posedge clk);
            #1;
            if (!stalled) done = 1;
            else chk("bubble_valid", mem_packet_out.valid, 1'b0);
        end
        mem2proc_ready  = 1'b0;
        mem2proc_rvalid = 1'b0;
        mem2proc_err    = 1'b0;
        if (!done) chk("retire_timeout", 64'd0, 64'd1);

        if (!is_mem || mis)  exp_stall = 0;
        else if (p.wr_mem)   exp_stall = 1 + rdy_dly;
        else                 exp_stall = 1 + rdy_dly + rv_dly;
        chk("stall_cycles", stall_cnt, exp_stall);
        chk("bus_request", req_seen, is_mem && !mis);

        exp_ill = p.illegal | mis | (is_mem && !mis && err);
        if (!is_mem)       exp_res = p.alu_result;
        else if (p.wr_mem) exp_res = '0;
        else               exp_res = model_load(rd, lane, p.mem_size);
        chk("out_valid", mem_packet_out.valid, p.valid);
        chk("out_illegal", mem_packet_out.illegal, exp_ill);
        chk("out_dest", mem_packet_out.dest_reg_addr, mis ? 5'd0 : p.dest_reg_addr);
        chk("out_npc", mem_packet_out.NPC, p.NPC);
        chk("out_halt", mem_packet_out.halt, p.halt);
        chk("out_csr", mem_packet_out.csr_op, p.csr_op);
        if (!mis) chk("out_result", mem_packet_out.result, exp_res);
        res_o = mem_packet_out.result;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        EX_MEM_PACKET p;
        logic [63:0]  res;
        logic [2:0]   f3;
        int unsigned  kind;
        bit           seen;

        rst             = 1'b1;
        ex_packet_in    = '0;
        mem2proc_ready  = 1'b0;
        mem2proc_rvalid = 1'b0;
        mem2proc_err    = 1'b0;
        mem2proc_rdata  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out", mem_packet_out, '0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_p2m_valid", proc2mem_valid, 1'b0);

        // ALU pass-through
        p = mk(64'h10, 64'h0, 1'b0, 1'b0, 3'd0, 5'd3);
        run_instr(p, 0, 1, 1'b0, '0, res);
        chk("alu_result", res, 64'h10);

        // SB lane 3, ready after 2 cycles
        p = mk(64'h1003, 64'hAB, 1'b0, 1'b1, 3'd0, 5'd0);
        run_instr(p, 2, 1, 1'b0, '0, res);

        // LB / LBU, rvalid 3 cycles after accept
        p = mk(64'h2005, 64'h0, 1'b1, 1'b0, 3'd0, 5'd7);
        run_instr(p, 0, 3, 1'b0, 64'h0000_8000_0000_0000, res);
        chk("lb_value", res, 64'hFFFF_FFFF_FFFF_FF80);
        p = mk(64'h2005, 64'h0, 1'b1, 1'b0, 3'd4, 5'd7);
        run_instr(p, 0, 3, 1'b0, 64'h0000_8000_0000_0000, res);
        chk("lbu_value", res, 64'h80);

        // Misaligned LW
        p = mk(64'h3002, 64'h0, 1'b1, 1'b0, 3'd2, 5'd9);
        run_instr(p, 0, 1, 1'b0, '0, res);

        // Load with error on the response
        p = mk(64'h5008, 64'h0, 1'b1, 1'b0, 3'd3, 5'd4);
        run_instr(p, 1, 2, 1'b1, 64'h1122_3344_5566_7788, res);

        // Reset while waiting for a load response; the late rvalid must be ignored
        ex_packet_in = mk(64'h4000, 64'h0, 1'b1, 1'b0, 3'd3, 5'd5);
        seen = 0;
        for (int unsigned c = 0; c < 8 && !seen; c++) begin
            #1;
            if (proc2mem_valid) begin
                seen = 1;
                mem2proc_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            mem2proc_ready = 1'b0;
        end
        chk("rstmid_req_seen", seen, 1'b1);
        chk("rstmid_resp_stall", mem_stall, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_packet_in = mk(64'h55, 64'h0, 1'b0, 1'b0, 3'd0, 5'd6);
        #1;
        chk("rstmid_out", mem_packet_out, '0);
        chk("rstmid_stall", mem_stall, 1'b0);
        chk("rstmid_p2m_valid", proc2mem_valid, 1'b0);
        mem2proc_rvalid = 1'b1;
        mem2proc_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk);
        #1;
        mem2proc_rvalid = 1'b0;
        chk("late_rvalid_valid", mem_packet_out.valid, 1'b1);
        chk("late_rvalid_result", mem_packet_out.result, 64'h55);
        chk("late_rvalid_dest", mem_packet_out.dest_reg_addr, 5'd6);

        // Randomized mix
        for (int unsigned n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 6));
            if (f3 == 3'd7 || f3[1:0] == 2'd3) f3 = 3'd3;
            p = mk({$urandom, $urandom}, {$urandom, $urandom}, kind == 1, kind == 2,
                   (kind == 2) ? {1'b0, f3[1:0]} : f3, 5'($urandom));
            if ($urandom_range(0, 1) == 0)
                p.alu_result = p.alu_result & ~((64'd1 << p.mem_size[1:0]) - 64'd1);
            p.valid   = ($urandom_range(0, 9) != 0);
            p.illegal = ($urandom_range(0, 9) == 0);
            p.halt    = ($urandom_range(0, 15) == 0);
            p.csr_op  = ($urandom_range(0, 7) == 0);
            run_instr(p, $urandom_range(0, 3), $urandom_range(1, 4),
                      ($urandom_range(0, 7) == 0), {$urandom, $urandom}, res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. It consumes EX_MEM_PACKET and produces a registered MEM_WB_PACKET for writeback.
- Performs loads and stores over a single-outstanding valid/ready data-memory port:
  - byte-lane alignment, store strobes, load sign/zero extension;
  - misalignment trap.
- Stalls upstream while a memory access is in flight.

Parameters:
- DATA_WIDTH, 64, datapath/address width; must match `DATA_WIDTH.
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.

Ports:
- clk  input  1  Clock; all state updates on its rising edge.
- rst  input  1  Reset, synchronous, active-high.
- ex_packet_in  input  EX_MEM_PACKET  From execute stage. Fields used: alu_result (address or result), rs2_value, rd_mem, wr_mem, mem_size, dest_reg_addr, NPC, halt, illegal, csr_op, valid.
- mem_stall  output  1  High: upstream must hold ex_packet_in stable and not advance.
- proc2mem_valid  output  1  Request valid.
- proc2mem_we  output  1  1 = store, 0 = load.
- proc2mem_addr  output  DATA_WIDTH  Doubleword-aligned address (low 3 bits zero).
- proc2mem_wdata  output  DATA_WIDTH  Store data, lane-shifted.
- proc2mem_wstrb  output  STRB_WIDTH  Byte enables (stores only; 0 for loads).
- mem2proc_ready  input  1  Request accepted when proc2mem_valid && mem2proc_ready.
- mem2proc_rvalid  input  1  Load response valid.
- mem2proc_rdata  input  DATA_WIDTH  Load response data (full doubleword).
- mem2proc_err  input  1  Bus error; sampled with ready (stores) or rvalid (loads).
- mem_packet_out  output  MEM_WB_PACKET  Registered result: result, dest_reg_addr, NPC, halt, illegal, csr_op, valid.

Behaviour:
- Reset (rst=1 at clock edge):
  - FSM returns to IDLE.
  - mem_packet_out is zeroed (valid=0).
  - proc2mem_valid=0; mem_stall=0.
  - Reset mid-transaction abandons the access; any late rvalid is ignored until a new request is issued.
- FSM states: IDLE, REQ, RESP.
- IDLE, entered each cycle with a valid packet:
  - Not rd_mem/wr_mem, or valid=0: register pass-through next cycle (result=alu_result, other fields copied). Latency 1, no stall.
  - Misaligned access (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0): no bus request. mem_packet_out next cycle has illegal=1, dest_reg_addr=0 (no writeback). Latency 1.
  - Aligned memory op: go to REQ; mem_stall=1 combinationally in this cycle.
- REQ:
  - proc2mem_valid=1 with stable address, we, wdata, wstrb until accepted.
  - Store accepted: go to IDLE; mem_packet_out registered with result=0; illegal |= mem2proc_err.
  - Load accepted: go to RESP.
  - mem_stall=1 throughout, deasserted in the accepting cycle for stores.
- RESP:
  - Wait for mem2proc_rvalid. On rvalid: register the extracted load value, illegal |= mem2proc_err, go to IDLE.
  - mem_stall=1 until and excluding the rvalid cycle.
  - rvalid in the same cycle as acceptance is not legal (the memory gives at least 1 cycle latency).
- While stalled, mem_packet_out.valid=0 (bubble into writeback). The instruction appears exactly once with valid=1.
- Address and lanes:
  - proc2mem_addr = {alu_result[63:3], 3'b0}; lane = alu_result[2:0].
- Store (mem_size[1:0]: 0=B, 1=H, 2=W, 3=D):
  - wdata = rs2_value replicated/shifted by lane*8.
  - wstrb = (1,3,15,255) << lane.
- Load: shifted = rdata >> lane*8, then by funct3:
  - LB/LH/LW sign-extend 8/16/32 bits.
  - LBU/LHU/LWU zero-extend.
  - LD uses the full 64 bits.
- Incoming halt/illegal flags pass through unchanged. An incoming illegal=1 suppresses the bus access and is treated as a pass-through.
- Simultaneous events:
  - ready and err in the same cycle: completes with illegal=1.
  - rst overrides all other inputs.

Decomposition:
- Shared sys_defs package:
  - MEM_WB_PACKET typedef;
  - MEM_STATE enum {IDLE, REQ, RESP};
  - MEM_SIZE encodings (BYTE, HALF, WORD, DOUBLE);
  - `DATA_WIDTH.
- One natural sub-module: mem_align, purely combinational. It produces store wdata/wstrb and the extracted, extended load value from lane, size, rs2_value and rdata. It is unit-testable separately.

Test Plan:
- ALU op (add, result 64'h10, valid=1, rd_mem=wr_mem=0) -> next cycle mem_packet_out.result=64'h10, valid=1, mem_stall never high, proc2mem_valid never high.
- SB, addr 64'h1003, rs2=64'hAB, ready held low 2 cycles then high -> addr=64'h1000, wstrb=8'h08, wdata[31:24]=8'hAB; stall high 3 cycles; one valid output, illegal=0.
- LB, addr 64'h2005, rdata=64'h0000_8000_0000_0000, rvalid 3 cycles after accept -> result=64'hFFFF_FFFF_FFFF_FF80. Same access with LBU -> 64'h80.
- LW at addr 64'h3002 (misaligned) -> no proc2mem_valid; next cycle illegal=1, dest_reg_addr=0, valid=1.
- LD accepted, rst asserted in RESP, rvalid arrives after reset -> outputs zero, FSM IDLE, late rvalid ignored, next ALU op completes normally.
- Load with rvalid and mem2proc_err both 1 -> illegal=1, valid=1, stall released that cycle.
